// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared state encoding and Ethernet constants for the RMII receive path
package eth_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DST,
    S_SRC,
    S_TYPE,
    S_PAYLOAD,
    S_DROP
  } eth_hdr_state_t;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [10:0] ETH_MAX_LEN  = 11'd1500;
  localparam logic [15:0] ETH_TYPE_MIN = 16'h0600;
  localparam logic [47:0] ETH_BCAST    = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_field_sr.sv
// rtl/eth_field_sr.sv - byte-wide MSB-first shift register for header field capture
module eth_field_sr #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [7:0]       din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-9:0], din};
    end
  end

endmodule

// File: rtl/eth_hdr_parser.sv
// rtl/eth_hdr_parser.sv - Ethernet header parser: preamble/SFD, dst filter, src/type capture, payload stream
module eth_hdr_parser
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h0000_0000_0000,
  parameter int unsigned PRE_MIN  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_vld,
  input  logic        cnt_busy,
  output logic        cnt_en,
  output logic [10:0] cnt,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type,
  output logic        hdr_done,
  output logic [7:0]  pl_byte,
  output logic        pl_vld,
  output logic        pl_last,
  output logic        frame_end,
  output logic        frame_drop
);

  localparam logic [2:0] PRE_MIN_C = 3'(PRE_MIN);

  eth_hdr_state_t state_q;
  logic [10:0] idx_q;
  logic [2:0]  pre_q;
  logic [10:0] len_q;
  logic        bounded_q;
  logic        hdr_seen_q;
  logic        cnt_en_q, hdr_done_q, pl_vld_q, pl_last_q, frame_end_q, frame_drop_q;
  logic [10:0] cnt_q;
  logic [7:0]  pl_byte_q;
  logic [39:0] dst_q;

  logic        sfd_ok, sfd_take, dst_hit, is_type, is_len, type_ok;
  logic        hdr_accept, hdr_now, hdr_pending;
  logic [15:0] type_word;

  assign sfd_ok    = (rx_byte == ETH_SFD) && (pre_q >= PRE_MIN_C);
  assign sfd_take  = rx_byte_vld && (state_q == S_PRE) && sfd_ok;
  // Only five dst bytes are stored; the sixth is compared straight off the input.
  assign dst_hit   = ({dst_q, rx_byte} == MAC_ADDR) || ({dst_q, rx_byte} == ETH_BCAST);
  assign type_word = {eth_type[7:0], rx_byte};
  assign is_type   = type_word >= ETH_TYPE_MIN;
  assign is_len    = (type_word != 16'h0000) && (type_word <= {5'b0, ETH_MAX_LEN});
  assign type_ok   = is_type || (is_len && !cnt_busy);

  assign hdr_accept = rx_byte_vld && (state_q == S_TYPE) && (idx_q == 11'd1) && type_ok;
  assign hdr_now    = hdr_seen_q || hdr_accept;
  // Header still in progress once the current byte is consumed: a carrier drop here is a truncation.
  assign hdr_pending =
    ((state_q == S_PRE) && sfd_take) ||
    ((state_q == S_DST) && !(rx_byte_vld && (idx_q == 11'd5) && !dst_hit)) ||
    (state_q == S_SRC) ||
    ((state_q == S_TYPE) && !(rx_byte_vld && (idx_q == 11'd1)));

  eth_field_sr #(.WIDTH(40)) u_dst_sr (
    .clk(clk), .rst_n(rst_n), .clr(sfd_take),
    .shift_en(rx_byte_vld && (state_q == S_DST)), .din(rx_byte), .q(dst_q)
  );

  eth_field_sr #(.WIDTH(48)) u_src_sr (
    .clk(clk), .rst_n(rst_n), .clr(sfd_take),
    .shift_en(rx_byte_vld && (state_q == S_SRC)), .din(rx_byte), .q(src_mac)
  );

  eth_field_sr #(.WIDTH(16)) u_type_sr (
    .clk(clk), .rst_n(rst_n), .clr(sfd_take),
    .shift_en(rx_byte_vld && (state_q == S_TYPE)), .din(rx_byte), .q(eth_type)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pre_q        <= '0;
      len_q        <= '0;
      bounded_q    <= 1'b0;
      hdr_seen_q   <= 1'b0;
      cnt_en_q     <= 1'b0;
      cnt_q        <= '0;
      hdr_done_q   <= 1'b0;
      pl_byte_q    <= '0;
      pl_vld_q     <= 1'b0;
      pl_last_q    <= 1'b0;
      frame_end_q  <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      cnt_en_q     <= 1'b0;
      hdr_done_q   <= 1'b0;
      pl_vld_q     <= 1'b0;
      pl_last_q    <= 1'b0;
      frame_end_q  <= 1'b0;
      frame_drop_q <= 1'b0;

      if (rx_byte_vld) begin
        case (state_q)
          S_IDLE: if (rx_dv && rx_byte == ETH_PREAMBLE) begin
            state_q    <= S_PRE;
            pre_q      <= 3'd1;
            hdr_seen_q <= 1'b0;
          end
          S_PRE: begin
            if (rx_byte == ETH_PREAMBLE) begin
              if (pre_q != 3'd7) pre_q <= pre_q + 3'd1;
            end else if (sfd_ok) begin
              state_q <= S_DST;
              idx_q   <= '0;
            end else begin
              state_q      <= S_DROP;
              frame_drop_q <= 1'b1;
            end
          end
          S_DST: begin
            idx_q <= idx_q + 11'd1;
            if (idx_q == 11'd5) begin
              idx_q <= '0;
              if (dst_hit) begin
                state_q <= S_SRC;
              end else begin
                state_q      <= S_DROP;
                frame_drop_q <= 1'b1;
              end
            end
          end
          S_SRC: begin
            idx_q <= idx_q + 11'd1;
            if (idx_q == 11'd5) begin
              idx_q   <= '0;
              state_q <= S_TYPE;
            end
          end
          S_TYPE: begin
            idx_q <= idx_q + 11'd1;
            if (idx_q == 11'd1) begin
              idx_q <= '0;
              if (type_ok) begin
                state_q    <= S_PAYLOAD;
                hdr_done_q <= 1'b1;
                hdr_seen_q <= 1'b1;
                bounded_q  <= !is_type;
                len_q      <= type_word[10:0];
                if (!is_type) begin
                  cnt_en_q <= 1'b1;
                  cnt_q    <= type_word[10:0];
                end
              end else begin
                state_q      <= S_DROP;
                frame_drop_q <= 1'b1;
              end
            end
          end
          S_PAYLOAD: begin
            pl_byte_q <= rx_byte;
            pl_vld_q  <= 1'b1;
            if (idx_q != 11'h7FF) idx_q <= idx_q + 11'd1;
            if (bounded_q && (idx_q == len_q - 11'd1)) begin
              pl_last_q <= 1'b1;
              state_q   <= S_DROP;
            end
          end
          default: ;
        endcase
      end

      // Carrier loss overrides whatever the byte above decided.
      if (!rx_dv && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        if (hdr_now) begin
          frame_end_q <= 1'b1;
        end else if (hdr_pending) begin
          frame_drop_q <= 1'b1;
        end
      end
    end
  end

  assign cnt_en     = cnt_en_q;
  assign cnt        = cnt_q;
  assign hdr_done   = hdr_done_q;
  assign pl_byte    = pl_byte_q;
  assign pl_vld     = pl_vld_q;
  assign pl_last    = pl_last_q;
  assign frame_end  = frame_end_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_eth_hdr_parser.sv
// tb/tb_eth_hdr_parser.sv - directed self-checking bench for eth_hdr_parser
module tb_eth_hdr_parser;

  localparam logic [47:0] MAC = 48'h02_11_22_33_44_55;
  localparam logic [47:0] SRC = 48'h0A_0B_0C_0D_0E_0F;
  localparam logic [47:0] BC  = 48'hFF_FF_FF_FF_FF_FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_byte_vld = 1'b0;
  logic        cnt_busy = 1'b0;
  logic        cnt_en;
  logic [10:0] cnt;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic        hdr_done;
  logic [7:0]  pl_byte;
  logic        pl_vld;
  logic        pl_last;
  logic        frame_end;
  logic        frame_drop;

  int n_chk = 0;
  int n_err = 0;
  int n_hdr, n_cnten, n_pl, n_last, n_end, n_drop;
  logic [10:0] cnt_seen;
  logic [7:0]  last_byte;

  eth_hdr_parser #(.MAC_ADDR(MAC), .PRE_MIN(3)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .rx_byte_vld(rx_byte_vld), .cnt_busy(cnt_busy), .cnt_en(cnt_en), .cnt(cnt),
    .src_mac(src_mac), .eth_type(eth_type), .hdr_done(hdr_done), .pl_byte(pl_byte),
    .pl_vld(pl_vld), .pl_last(pl_last), .frame_end(frame_end), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hdr_done) n_hdr++;
    if (cnt_en) begin n_cnten++; cnt_seen = cnt; end
    if (pl_vld) n_pl++;
    if (pl_vld && pl_last) begin n_last++; last_byte = pl_byte; end
    if (frame_end) n_end++;
    if (frame_drop) n_drop++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_hdr = 0; n_cnten = 0; n_pl = 0; n_last = 0; n_end = 0; n_drop = 0;
    cnt_seen = '0; last_byte = '0;
  endtask

  task automatic byte_in(input logic [7:0] b);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = b; rx_byte_vld = 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    rx_byte_vld = 1'b0;
  endtask

  task automatic carrier_off();
    @(negedge clk);
    rx_dv = 1'b0; rx_byte_vld = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic send_hdr(input int npre, input logic [47:0] dst, input logic [47:0] src,
                          input logic [15:0] typ);
    for (int i = 0; i < npre; i++) byte_in(8'h55);
    byte_in(8'hD5);
    gap();
    for (int i = 0; i < 6; i++) byte_in(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) byte_in(src[47-8*i -: 8]);
    byte_in(typ[15:8]);
    byte_in(typ[7:0]);
  endtask

  task automatic send_pl(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) byte_in(base + 8'(i));
  endtask

  initial begin
    clear_counts();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_src_mac", src_mac, 0);
    chk("rst_eth_type", eth_type, 0);
    chk("rst_pl_vld", pl_vld, 0);
    chk("rst_frame_drop", frame_drop, 0);
    rst_n = 1'b1;

    // length frame, 4 payload bytes then pad
    clear_counts();
    send_hdr(7, MAC, SRC, 16'h0004);
    send_pl(4, 8'h10);
    send_pl(3, 8'h00);
    carrier_off();
    chk("len4_hdr_done", n_hdr, 1);
    chk("len4_cnt_en", n_cnten, 1);
    chk("len4_cnt", cnt_seen, 4);
    chk("len4_pl_vld", n_pl, 4);
    chk("len4_pl_last", n_last, 1);
    chk("len4_last_byte", last_byte, 8'h13);
    chk("len4_frame_end", n_end, 1);
    chk("len4_frame_drop", n_drop, 0);
    chk("len4_src_mac", src_mac, SRC);
    chk("len4_eth_type", eth_type, 16'h0004);

    // broadcast, type frame
    clear_counts();
    send_hdr(7, BC, SRC, 16'h0800);
    send_pl(10, 8'h40);
    carrier_off();
    chk("type_hdr_done", n_hdr, 1);
    chk("type_cnt_en", n_cnten, 0);
    chk("type_pl_vld", n_pl, 10);
    chk("type_pl_last", n_last, 0);
    chk("type_eth_type", eth_type, 16'h0800);
    chk("type_frame_end", n_end, 1);

    // dst mismatch in last byte
    clear_counts();
    send_hdr(7, MAC ^ 48'h1, SRC, 16'h0004);
    send_pl(4, 8'h10);
    carrier_off();
    chk("dstmis_frame_drop", n_drop, 1);
    chk("dstmis_pl_vld", n_pl, 0);
    chk("dstmis_hdr_done", n_hdr, 0);
    chk("dstmis_frame_end", n_end, 0);
    chk("dstmis_eth_type_cleared", eth_type, 0);

    // length frame while counter busy
    clear_counts();
    cnt_busy = 1'b1;
    send_hdr(7, MAC, SRC, 16'h0010);
    send_pl(4, 8'h20);
    carrier_off();
    cnt_busy = 1'b0;
    chk("busy_frame_drop", n_drop, 1);
    chk("busy_cnt_en", n_cnten, 0);
    chk("busy_hdr_done", n_hdr, 0);
    chk("busy_eth_type", eth_type, 16'h0010);

    // short preamble: SFD rejected, fields untouched
    clear_counts();
    send_hdr(2, MAC, SRC, 16'h0004);
    carrier_off();
    chk("shortpre_frame_drop", n_drop, 1);
    chk("shortpre_hdr_done", n_hdr, 0);
    chk("shortpre_eth_type_kept", eth_type, 16'h0010);

    // length 1501 rejected with minimum preamble
    clear_counts();
    send_hdr(3, MAC, SRC, 16'h05DD);
    carrier_off();
    chk("len1501_frame_drop", n_drop, 1);
    chk("len1501_hdr_done", n_hdr, 0);
    chk("len1501_eth_type", eth_type, 16'h05DD);

    // length 1500 accepted, frame cut short in payload
    clear_counts();
    send_hdr(3, BC, SRC, 16'h05DC);
    send_pl(5, 8'h60);
    carrier_off();
    chk("len1500_cnt", cnt_seen, 11'd1500);
    chk("len1500_cnt_en", n_cnten, 1);
    chk("len1500_pl_vld", n_pl, 5);
    chk("len1500_pl_last", n_last, 0);
    chk("len1500_frame_end", n_end, 1);
    chk("len1500_frame_drop", n_drop, 0);

    // truncated header: carrier lost after 3 src bytes
    clear_counts();
    for (int i = 0; i < 7; i++) byte_in(8'h55);
    byte_in(8'hD5);
    for (int i = 0; i < 6; i++) byte_in(MAC[47-8*i -: 8]);
    for (int i = 0; i < 3; i++) byte_in(SRC[47-8*i -: 8]);
    carrier_off();
    chk("trunc_frame_drop", n_drop, 1);
    chk("trunc_frame_end", n_end, 0);
    chk("trunc_src_mac", src_mac, 48'h0000_000A_0B0C);

    // reset mid-payload
    clear_counts();
    send_hdr(7, MAC, SRC, 16'h0800);
    send_pl(3, 8'h70);
    #1;
    chk("prerst_pl_vld", pl_vld, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pl_vld", pl_vld, 0);
    chk("midrst_pl_byte", pl_byte, 0);
    chk("midrst_src_mac", src_mac, 0);
    chk("midrst_eth_type", eth_type, 0);
    chk("midrst_frame_drop", frame_drop, 0);
    @(negedge clk);
    rx_dv = 1'b0; rx_byte_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("postrst_no_drop", n_drop, 0);

    // clean frame after reset
    clear_counts();
    send_hdr(7, MAC, 48'h12_34_56_78_9A_BC, 16'h0002);
    send_pl(2, 8'hAA);
    send_pl(2, 8'h00);
    carrier_off();
    chk("after_cnt", cnt_seen, 2);
    chk("after_pl_vld", n_pl, 2);
    chk("after_last_byte", last_byte, 8'hAB);
    chk("after_frame_end", n_end, 1);
    chk("after_src_mac", src_mac, 48'h12_34_56_78_9A_BC);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
